// File: rtl/irq_event_queue.sv
// Peripheral-side interrupt agent: queues events in a small FIFO and drives the
// irq/iack/iend handshake for the oldest queued event.
module irq_event_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              evValid,
    input  logic [DATA_W-1:0] evData,
    output logic              irq,
    input  logic              iack,
    input  logic              iend,
    output logic [DATA_W-1:0] dataOut,
    output logic              busy,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              protoError
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERV
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              pending;
    logic              ack_ok;
    logic              end_ok;
    logic              full;
    logic              push;
    logic              pop;
    logic              viol;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        ack_ok = iack && !iend && (state == REQ);
        end_ok = iend && !iack && (state == SERV);
        pop    = end_ok;
        full   = (count == CNT_W'(DEPTH));
        // A same-edge pop frees the slot, so a push into a full queue still lands.
        push   = evValid && (!full || pop);
        viol   = (iack && iend) || (iack && (state != REQ)) || (iend && (state != SERV));
    end

    always_comb begin
        dataOut = (count != '0) ? mem[head] : '0;
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[tail] <= evData;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            irq        <= 1'b0;
            busy       <= 1'b0;
            count      <= '0;
            head       <= '0;
            tail       <= '0;
            pending    <= 1'b0;
            overflow   <= 1'b0;
            protoError <= 1'b0;
        end else begin
            if (push) begin
                tail <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (evValid && !push) begin
                overflow <= 1'b1;
            end
            if (viol) begin
                protoError <= 1'b1;
            end
            // pending trails count by one edge: a fresh event into an empty queue
            // waits an extra cycle, while a backlog after iend re-requests at once.
            pending <= (count != '0);

            case (state)
                IDLE: begin
                    irq  <= 1'b0;
                    busy <= 1'b0;
                    if ((count != '0) && pending) begin
                        state <= REQ;
                        irq   <= 1'b1;
                    end
                end
                REQ: begin
                    if (ack_ok) begin
                        state <= SERV;
                        irq   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                SERV: begin
                    if (end_ok) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    irq   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_event_queue.sv
// Directed bench for irq_event_queue: stimulus queues expected service data,
// a monitor checks dataOut each time a service begins.
module tb_irq_event_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              CLK;
    logic              RESET;
    logic              evValid;
    logic [DATA_W-1:0] evData;
    logic              irq;
    logic              iack;
    logic              iend;
    logic [DATA_W-1:0] dataOut;
    logic              busy;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              protoError;

    int tests = 0;
    int fails = 0;
    logic [DATA_W-1:0] exp_q[$];

    irq_event_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .evValid(evValid),
        .evData(evData),
        .irq(irq),
        .iack(iack),
        .iend(iend),
        .dataOut(dataOut),
        .busy(busy),
        .count(count),
        .overflow(overflow),
        .protoError(protoError)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One active edge; single-cycle strobes are dropped just after it.
    task automatic edge_step();
        @(posedge CLK);
        #1;
        evValid = 1'b0;
        iack    = 1'b0;
        iend    = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        edge_step();
        RESET = 1'b0;
        exp_q.delete();
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input bit accepted);
        evValid = 1'b1;
        evData  = d;
        if (accepted) exp_q.push_back(d);
        edge_step();
    endtask

    task automatic wait_irq();
        int n = 0;
        while (!irq && n < 8) begin
            edge_step();
            n++;
        end
        check("irq_wait", {31'b0, irq}, 32'd1);
    endtask

    task automatic serve();
        wait_irq();
        iack = 1'b1;
        edge_step();
        check("serve_busy", {31'b0, busy}, 32'd1);
        iend = 1'b1;
        edge_step();
        check("serve_done", {31'b0, busy}, 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_irq"}, {31'b0, irq}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_data"}, 32'(dataOut), 32'd0);
        check({tag, "_ovf"}, {31'b0, overflow}, 32'd0);
        check({tag, "_perr"}, {31'b0, protoError}, 32'd0);
    endtask

    // Scoreboard monitor: each new service must present the oldest expected entry.
    initial begin
        logic busy_q;
        busy_q = 1'b0;
        forever begin
            @(negedge CLK);
            if (busy && !busy_q) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected at %0t: got service of %h expected none", $time, dataOut);
                end else begin
                    check("sb_data", 32'(dataOut), 32'(exp_q.pop_front()));
                end
            end
            busy_q = busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET   = 1'b1;
        evValid = 1'b0;
        evData  = '0;
        iack    = 1'b0;
        iend    = 1'b0;
        edge_step();
        do_reset();
        check_reset_vals("rst");

        // Single event with exact latencies.
        push(8'h41, 1'b1);
        check("t1_count", 32'(count), 32'd1);
        check("t1_data", 32'(dataOut), 32'h41);
        check("t1_irq_e1", {31'b0, irq}, 32'd0);
        edge_step();
        check("t1_irq_e2", {31'b0, irq}, 32'd0);
        edge_step();
        check("t1_irq_e3", {31'b0, irq}, 32'd1);
        edge_step();
        iack = 1'b1;
        edge_step();
        check("t1_irq_e5", {31'b0, irq}, 32'd0);
        check("t1_busy_e5", {31'b0, busy}, 32'd1);
        edge_step();
        edge_step();
        check("t1_busy_e7", {31'b0, busy}, 32'd1);
        check("t1_data_e7", 32'(dataOut), 32'h41);
        iend = 1'b1;
        edge_step();
        check("t1_busy_e8", {31'b0, busy}, 32'd0);
        check("t1_count_e8", 32'(count), 32'd0);
        check("t1_data_e8", 32'(dataOut), 32'd0);
        edge_step();
        check("t1_irq_e9", {31'b0, irq}, 32'd0);

        // FIFO order, back-to-back service with a one-cycle irq gap.
        push(8'h01, 1'b1);
        push(8'h02, 1'b1);
        push(8'h03, 1'b1);
        serve();
        edge_step();
        check("t2_gap1", {31'b0, irq}, 32'd1);
        serve();
        edge_step();
        check("t2_gap2", {31'b0, irq}, 32'd1);
        serve();
        edge_step();
        check("t2_idle", {31'b0, irq}, 32'd0);
        check("t2_ovf", {31'b0, overflow}, 32'd0);

        // Overflow: fifth push is dropped.
        push(8'hA0, 1'b1);
        push(8'hA1, 1'b1);
        push(8'hA2, 1'b1);
        push(8'hA3, 1'b1);
        check("t3_ovf_pre", {31'b0, overflow}, 32'd0);
        push(8'hA4, 1'b0);
        check("t3_count", 32'(count), 32'd4);
        check("t3_ovf", {31'b0, overflow}, 32'd1);
        for (int i = 0; i < 4; i++) serve();
        check("t3_empty", 32'(count), 32'd0);

        // Full queue with same-edge pop and push.
        do_reset();
        push(8'hB0, 1'b1);
        push(8'hB1, 1'b1);
        push(8'hB2, 1'b1);
        push(8'hB3, 1'b1);
        wait_irq();
        iack = 1'b1;
        edge_step();
        iend    = 1'b1;
        evValid = 1'b1;
        evData  = 8'h99;
        exp_q.push_back(8'h99);
        edge_step();
        check("t4_count", 32'(count), 32'd4);
        check("t4_ovf", {31'b0, overflow}, 32'd0);
        for (int i = 0; i < 4; i++) serve();
        check("t4_empty", 32'(count), 32'd0);

        // Protocol violations.
        iack = 1'b1;
        edge_step();
        check("t5_idle_perr", {31'b0, protoError}, 32'd1);
        check("t5_idle_busy", {31'b0, busy}, 32'd0);
        check("t5_idle_irq", {31'b0, irq}, 32'd0);
        do_reset();
        push(8'hC1, 1'b1);
        wait_irq();
        iack = 1'b1;
        iend = 1'b1;
        edge_step();
        check("t5_both_perr", {31'b0, protoError}, 32'd1);
        check("t5_both_irq", {31'b0, irq}, 32'd1);
        check("t5_both_busy", {31'b0, busy}, 32'd0);
        serve();
        do_reset();
        push(8'hC2, 1'b1);
        wait_irq();
        iend = 1'b1;
        edge_step();
        check("t5_end_perr", {31'b0, protoError}, 32'd1);
        check("t5_end_irq", {31'b0, irq}, 32'd1);
        check("t5_end_count", 32'(count), 32'd1);

        // Reset in the middle of service.
        do_reset();
        push(8'hD0, 1'b1);
        push(8'hD1, 1'b1);
        push(8'hD2, 1'b1);
        wait_irq();
        iack = 1'b1;
        edge_step();
        check("t6_busy", {31'b0, busy}, 32'd1);
        check("t6_count", 32'(count), 32'd3);
        do_reset();
        check_reset_vals("t6_rst");
        push(8'h5A, 1'b1);
        check("t6_irq_n", {31'b0, irq}, 32'd0);
        edge_step();
        check("t6_irq_n1", {31'b0, irq}, 32'd0);
        edge_step();
        check("t6_irq_n2", {31'b0, irq}, 32'd1);
        check("t6_data", 32'(dataOut), 32'h5A);
        serve();
        edge_step();
        edge_step();
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/irq_event_queue.md
Name: irq_event_queue

Overview:
- Peripheral-side agent for the interrupt controller's per-source irq/iack/iend handshake: it raises a request, takes the acknowledge, and completes service.
- Peripherals (system timer, keyboard, future sources) push events with a data word into a small FIFO.
- The block raises irq for the oldest queued event, presents its data while the processor services it, and retires the event on iend.
- One instance sits between each peripheral and its pIrq/pIack/pIend slot of the interrupt controller.

Parameters:
- DEPTH, 4, number of event entries in the queue (2..16).
- DATA_W, 8, width of the event data word.
- CNT_W, clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- evValid  in  1  single-cycle event push strobe from the peripheral.
- evData  in  DATA_W  event data, sampled with evValid.
- irq  out  1  interrupt request to the controller (registered).
- iack  in  1  one-cycle acknowledge from the controller.
- iend  in  1  one-cycle end-of-service from the controller.
- dataOut  out  DATA_W  head-of-queue data.
- busy  out  1  high while an event is in service.
- count  out  CNT_W  queued events, including the one in service.
- overflow  out  1  sticky; an event was dropped.
- protoError  out  1  sticky; handshake violation seen.

Behaviour:
- Reset:
  - The state machine goes to IDLE.
  - irq=0, busy=0, count=0, dataOut=0, overflow=0, protoError=0.
  - FIFO pointers are cleared and queued contents are discarded.
  - Reset during REQ or SERV drops all events; irq is 0 after the reset edge.
- FIFO:
  - Circular buffer with head/tail pointers that wrap at DEPTH.
  - count updates on the edge after a push or pop.
- Push:
  - evValid=1 at an edge with count<DEPTH writes evData at the tail.
  - Push and pop on the same edge: both take effect and count is unchanged. This applies even when count==DEPTH, because the pop frees the slot in that cycle.
  - evValid with count==DEPTH and no same-edge pop drops the event and sets overflow.
- dataOut:
  - Shows the head entry whenever count>0, and 0 when empty.
  - Stays stable from iack through iend, because pushes only write the tail.
- State machine (state = IDLE / REQ / SERV):
  - IDLE: irq=0, busy=0. Moves to REQ at the next edge if count>0.
  - REQ: irq=1. On iack, moves to SERV at that edge.
  - SERV: irq=0, busy=1. On iend, pops the head and returns to IDLE.
  - irq is therefore low for at least one cycle between consecutive events.
- Latency:
  - An event pushed into an empty queue at edge N gives count=1 after N and irq=1 after N+2.
  - iack at edge M gives irq=0 and busy=1 after M.
  - iend at edge K gives busy=0, count decremented, and dataOut = next entry after K. irq rises again after K+1 if count>0.
- Handshake violations (the event is otherwise ignored and the state is unchanged; protoError is set):
  - iack outside REQ.
  - iend outside SERV.
  - iack and iend both high in the same cycle; this is always a violation.
- Sticky flags are cleared only by RESET.

Test Plan:
- Single event:
  - Stimulus: evValid with evData=0x41 at edge 1; iack at edge 5; iend at edge 8.
  - Required: irq=1 after edge 3, irq=0 after edge 5; busy=1 over edges 5..8; dataOut=0x41 throughout; after edge 8, count=0, dataOut=0, irq stays 0.
- FIFO order with back-to-back service:
  - Stimulus: push 0x01, 0x02, 0x03 on consecutive edges, then serve each event.
  - Required: dataOut is 0x01, then 0x02, then 0x03 during the respective SERV; irq low for exactly one cycle between services; overflow=0.
- Overflow with DEPTH=4:
  - Stimulus: push 5 events with no service.
  - Required: count=4, overflow=1, 5th value absent; serving all four returns the first four values in order.
- Full plus simultaneous pop:
  - Stimulus: with count=4 in SERV, assert iend and evValid (0x99) on the same edge.
  - Required: count stays 4, overflow stays 0, 0x99 appears as the last entry.
- Protocol errors:
  - iack while IDLE: protoError=1, state unchanged.
  - After reset, iend while REQ: protoError=1, irq stays 1.
  - iack and iend together in REQ: protoError=1, no transition.
- Reset mid-service:
  - Stimulus: with count=3 in SERV, assert RESET for 1 cycle.
  - Required: all outputs at reset values after that edge; a new push then yields irq after 2 edges with the correct data.
